mult_datapath: RTL

MULT_DATAPATH -- requirements
Module: mult_datapath

---
 rtl/mult_datapath_if.sv | 41 ++++
 rtl/mult_datapath.sv | 118 +++++++++++
 2 files changed

// File: rtl/mult_datapath_if.sv
// ----------------------------------------------------------------------------
// mult_datapath_if
// Bundles the control strobes, the switch operand and the observable outputs
// of the add-shift multiplier datapath.
//   master : control side. It drives Clr_Ld/Shift/Add/Sub/S and observes the
//            results.
//   slave  : the datapath. It receives the strobes and S, and drives Aval,
//            Bval, X, M and the four seven-segment codes.
// Signals:
//   Clr_Ld, Shift, Add, Sub : operation strobes (1 bit each)
//   S                       : 8-bit two's-complement operand
//   Aval, Bval              : registers A (upper byte) and B (lower byte)
//   X                       : sign-extension flip-flop
//   M                       : B[0], fed back to the control unit
//   AhexU/AhexL/BhexU/BhexL : active-low seven-segment codes, bit order gfedcba
// ----------------------------------------------------------------------------
interface mult_datapath_if;
  logic       Clr_Ld;
  logic       Shift;
  logic       Add;
  logic       Sub;
  logic [7:0] S;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;
  logic       M;
  logic [6:0] AhexU;
  logic [6:0] AhexL;
  logic [6:0] BhexU;
  logic [6:0] BhexL;

  modport master (
    output Clr_Ld, Shift, Add, Sub, S,
    input  Aval, Bval, X, M, AhexU, AhexL, BhexU, BhexL
  );

  modport slave (
    input  Clr_Ld, Shift, Add, Sub, S,
    output Aval, Bval, X, M, AhexU, AhexL, BhexU, BhexL
  );
endinterface

// File: rtl/mult_datapath.sv
// ----------------------------------------------------------------------------
// mult_datapath
// Datapath of an 8x8 signed add-shift multiplier. A holds the upper product
// byte and B the lower byte. X is the sign-extension bit that feeds A[7]
// during a right shift.
// Ports:
//   Clk   : system clock; all state updates on the rising edge
//   Reset : asynchronous, active-low reset of A, B and X
//   bus   : mult_datapath_if.slave (strobes, S, Aval/Bval/X/M, hex codes)
// Only one operation takes effect per edge. The priority order is
// Clr_Ld > Sub > Add > Shift.
// Configuration macro: MULT_HEX_EN. When it is defined, four hex-to-seven-
// segment decoders drive the hex outputs. When it is undefined, those outputs
// are tied to 7'h7F (blank).
// ----------------------------------------------------------------------------
module mult_datapath (
  input logic          Clk,
  input logic          Reset,
  mult_datapath_if.slave bus
);

  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       x_q, x_d;
  logic [8:0] operand_s;
  logic [8:0] sum_s;

  // Shared 9-bit adder. Sub adds the ones-complement of the sign-extended S
  // with a carry-in of 1.
  always_comb begin
    operand_s = {bus.S[7], bus.S};
    if (bus.Sub) begin
      operand_s = ~{bus.S[7], bus.S};
    end else begin
      operand_s = {bus.S[7], bus.S};
    end
    sum_s = {a_q[7], a_q} + operand_s + {8'd0, bus.Sub};
  end

  // Next-state selection in priority order; S only matters for load/add/sub.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    x_d = x_q;
    if (bus.Clr_Ld) begin
      a_d = 8'h00;
      x_d = 1'b0;
      b_d = bus.S;
    end else if (bus.Sub || bus.Add) begin
      a_d = sum_s[7:0];
      x_d = sum_s[8];
    end else if (bus.Shift) begin
      a_d = {x_q, a_q[7:1]};
      b_d = {a_q[0], b_q[7:1]};
    end else begin
      a_d = a_q;
      b_d = b_q;
      x_d = x_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_q <= 8'h00;
      b_q <= 8'h00;
      x_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      x_q <= x_d;
    end
  end

  assign bus.Aval = a_q;
  assign bus.Bval = b_q;
  assign bus.X    = x_q;
  // M is combinational so control sees the new B[0] right after a shift.
  assign bus.M    = b_q[0];

`ifdef MULT_HEX_EN
  // Active-low gfedcba pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign bus.AhexU = hex7(a_q[7:4]);
  assign bus.AhexL = hex7(a_q[3:0]);
  assign bus.BhexU = hex7(b_q[7:4]);
  assign bus.BhexL = hex7(b_q[3:0]);
`else
  assign bus.AhexU = 7'h7F;
  assign bus.AhexL = 7'h7F;
  assign bus.BhexU = 7'h7F;
  assign bus.BhexL = 7'h7F;
`endif

endmodule
